qspi_sram_target: RTL and testbench

//  Synthesizable QSPI SRAM responder: the device end of the bus driven by the QSPI_SRAM initiator.

---
 rtl/qspi_tgt_pkg.sv | 40 ++++
 rtl/qspi_sram_target_if.sv | 29 ++
 rtl/qspi_tgt_sync.sv | 59 +++++
 rtl/qspi_sram_target.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_qspi_sram_target.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_tgt_pkg.sv
// Package qspi_tgt_pkg
// Shared constants and types for the QSPI SRAM target: command opcodes,
// FSM state encoding, addressing modes, and nibble counts for the address
// and dummy phases.
// Optional feature macro: QSPI_TGT_MODE_REG_EN (mode register commands),
// consumed by qspi_sram_target.sv.
package qspi_tgt_pkg;

  localparam logic [7:0] CMD_WRMR  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDMR  = 8'h05;

  localparam int ADDR_NIB  = 4;  // 16-bit address, high nibble first
  localparam int DUMMY_NIB = 2;  // dummy rising edges before read data

  // Mode register value after reset: sequential mode.
  localparam logic [7:0] MR_RESET = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE,
    ST_WRMR,
    ST_RDMR
  } state_t;

  // Encodings match MR[7:6].
  typedef enum logic [1:0] {
    MODE_BYTE    = 2'b00,
    MODE_SEQ     = 2'b01,
    MODE_PAGE    = 2'b10,
    MODE_SEQ_ALT = 2'b11
  } mode_t;

endpackage

// File: rtl/qspi_sram_target_if.sv
// Interface qspi_sram_target_if
// Pin-level QSPI bus between an initiator (master modport) and the SRAM
// target (slave modport), plus the target's status outputs.
//   QSPI_CS_N  : chip select, active low
//   QSPI_SCK   : serial clock, SPI mode 0
//   QSPI_SIO_I : nibble from the pins into the target
//   QSPI_SIO_O : nibble driven by the target
//   QSPI_SIO_E : per-line output enable from the target
//   BUSY       : target sees chip select active
//   CMD_ERR    : one-clock pulse on an unsupported command byte
interface qspi_sram_target_if;
  logic       QSPI_CS_N;
  logic       QSPI_SCK;
  logic [3:0] QSPI_SIO_I;
  logic [3:0] QSPI_SIO_O;
  logic [3:0] QSPI_SIO_E;
  logic       BUSY;
  logic       CMD_ERR;

  modport master (
    output QSPI_CS_N, QSPI_SCK, QSPI_SIO_I,
    input  QSPI_SIO_O, QSPI_SIO_E, BUSY, CMD_ERR
  );

  modport slave (
    input  QSPI_CS_N, QSPI_SCK, QSPI_SIO_I,
    output QSPI_SIO_O, QSPI_SIO_E, BUSY, CMD_ERR
  );
endinterface

// File: rtl/qspi_tgt_sync.sv
// Module qspi_tgt_sync
// Brings the asynchronous QSPI pins into the CLK domain through SYNC_N
// flops each and derives single-cycle edge pulses from the synchronized
// levels. SIO goes through the same depth as SCK so that the data seen
// with a rise pulse is the data present at the pin edge.
// Ports:
//   CLK, RES    : system clock, asynchronous active-high reset
//   cs_n_i      : raw chip select pin
//   sck_i       : raw serial clock pin
//   sio_i[3:0]  : raw data nibble
//   cs_n_o      : synchronized chip select (resets inactive/high)
//   sio_o[3:0]  : synchronized data nibble
//   sck_rise_o  : one-cycle pulse on synchronized SCK rise
//   sck_fall_o  : one-cycle pulse on synchronized SCK fall
//   cs_fall_o   : one-cycle pulse on synchronized CS_N fall
module qspi_tgt_sync #(
  parameter int SYNC_N = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       cs_n_i,
  input  logic       sck_i,
  input  logic [3:0] sio_i,
  output logic       cs_n_o,
  output logic [3:0] sio_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       cs_fall_o
);

  logic [SYNC_N-1:0]      cs_q;
  logic [SYNC_N-1:0]      sck_q;
  logic [SYNC_N-1:0][3:0] sio_q;
  logic                   cs_prev_q;
  logic                   sck_prev_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cs_q       <= '1;
      sck_q      <= '0;
      sio_q      <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      cs_q       <= {cs_q[SYNC_N-2:0], cs_n_i};
      sck_q      <= {sck_q[SYNC_N-2:0], sck_i};
      sio_q      <= {sio_q[SYNC_N-2:0], sio_i};
      cs_prev_q  <= cs_q[SYNC_N-1];
      sck_prev_q <= sck_q[SYNC_N-1];
    end
  end

  assign cs_n_o     = cs_q[SYNC_N-1];
  assign sio_o      = sio_q[SYNC_N-1];
  assign sck_rise_o =  sck_q[SYNC_N-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[SYNC_N-1] &  sck_prev_q;
  assign cs_fall_o  = ~cs_q[SYNC_N-1]  &  cs_prev_q;

endmodule

// File: rtl/qspi_sram_target.sv
// Module qspi_sram_target
// QSPI (SQI) SRAM responder emulating a 23LC512-style part backed by a
// 2**ADDR_W byte array. All pin activity is oversampled in CLK; QSPI_SCK
// never clocks any flop. Inputs are sampled on synchronized SCK rises,
// outputs change on synchronized SCK falls.
// Optional feature macro: QSPI_TGT_MODE_REG_EN adds WRMR (0x01) and
// RDMR (0x05) with byte/page/sequential addressing; without it the mode is
// fixed sequential and those opcodes are treated as unsupported.
// Ports:
//   CLK  : system clock
//   RES  : asynchronous active-high reset
//   bus  : qspi_sram_target_if slave modport (pins, BUSY, CMD_ERR)
module qspi_sram_target
  import qspi_tgt_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SYNC_N = 2
) (
  input  logic                CLK,
  input  logic                RES,
  qspi_sram_target_if.slave   bus
);

  logic       cs_n_s;
  logic [3:0] sio_s;
  logic       sck_rise;
  logic       sck_fall;
  logic       cs_fall;

  qspi_tgt_sync #(.SYNC_N(SYNC_N)) u_sync (
    .CLK        (CLK),
    .RES        (RES),
    .cs_n_i     (bus.QSPI_CS_N),
    .sck_i      (bus.QSPI_SCK),
    .sio_i      (bus.QSPI_SIO_I),
    .cs_n_o     (cs_n_s),
    .sio_o      (sio_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_fall_o  (cs_fall)
  );

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;       // nibble counter within a phase
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        hi_q, hi_d;         // high nibble of the byte in flight
  logic              rd_cmd_q, rd_cmd_d;
  logic [3:0]        sio_o_q, sio_o_d;
  logic [3:0]        sio_e_q, sio_e_d;
  logic              cmd_err_q, cmd_err_d;
  logic              bad_cmd;
  mode_t             mode;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_shift;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [0:(2**ADDR_W)-1];

`ifdef QSPI_TGT_MODE_REG_EN
  logic [7:0]        mr_q, mr_d;
  assign mode = mode_t'(mr_q[7:6]);
`else
  assign mode = MODE_SEQ;
`endif

  // A CS_N rise shows up as cs_n_s high in the same cycle as any coincident
  // SCK edge, so gating edges with cs_n_s gives CS_N priority.
  wire rise_v = sck_rise & ~cs_n_s;
  wire fall_v = sck_fall & ~cs_n_s;

  // Upper bus address bits simply shift out of the ADDR_W register (alias).
  assign addr_shift = {addr_q[ADDR_W-5:0], sio_s};
  assign mem_wdata  = {hi_q, sio_s};

  always_comb begin
    case (mode)
      MODE_BYTE: addr_inc = addr_q;
      MODE_PAGE: addr_inc = {addr_q[ADDR_W-1:5], addr_q[4:0] + 5'd1};
      default:   addr_inc = addr_q + ADDR_W'(1);
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      hi_q      <= 4'd0;
      rd_cmd_q  <= 1'b0;
      sio_o_q   <= 4'd0;
      sio_e_q   <= 4'd0;
      cmd_err_q <= 1'b0;
`ifdef QSPI_TGT_MODE_REG_EN
      mr_q      <= MR_RESET;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      rd_cmd_q  <= rd_cmd_d;
      sio_o_q   <= sio_o_d;
      sio_e_q   <= sio_e_d;
      cmd_err_q <= cmd_err_d;
`ifdef QSPI_TGT_MODE_REG_EN
      mr_q      <= mr_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    rd_cmd_d = rd_cmd_q;
    bad_cmd  = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = addr_q;
`ifdef QSPI_TGT_MODE_REG_EN
    mr_d     = mr_q;
`endif
    if (cs_n_s) begin
      // Any partially received write byte lives only in hi_q and is dropped.
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = 2'd0;
          end
        end
        ST_CMD: begin
          if (rise_v) begin
            if (cnt_q == 2'd0) begin
              hi_d  = sio_s;
              cnt_d = 2'd1;
            end else begin
              cnt_d = 2'd0;
              case ({hi_q, sio_s})
                CMD_WRITE: begin
                  state_d  = ST_ADDR;
                  rd_cmd_d = 1'b0;
                end
                CMD_READ: begin
                  state_d  = ST_ADDR;
                  rd_cmd_d = 1'b1;
                end
`ifdef QSPI_TGT_MODE_REG_EN
                CMD_WRMR: state_d = ST_WRMR;
                CMD_RDMR: state_d = ST_RDMR;
`endif
                default: begin
                  state_d = ST_IGNORE;
                  bad_cmd = 1'b1;
                end
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (rise_v) begin
            addr_d = addr_shift;
            if (cnt_q == 2'(ADDR_NIB - 1)) begin
              cnt_d = 2'd0;
              if (rd_cmd_q) begin
                // Prefetch the first byte so it is ready by the first data fall.
                state_d  = ST_DUMMY;
                mem_re   = 1'b1;
                mem_addr = addr_shift;
              end else begin
                state_d = ST_WDATA;
              end
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (rise_v) begin
            if (cnt_q == 2'(DUMMY_NIB - 1)) begin
              cnt_d   = 2'd0;
              state_d = ST_RDATA;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        ST_WDATA: begin
          if (rise_v) begin
            if (cnt_q == 2'd0) begin
              hi_d  = sio_s;
              cnt_d = 2'd1;
            end else begin
              mem_we   = 1'b1;
              mem_addr = addr_q;
              addr_d   = addr_inc;
              cnt_d    = 2'd0;
            end
          end
        end
        ST_RDATA: begin
          if (rise_v) begin
            if (cnt_q == 2'd0) begin
              cnt_d = 2'd1;
            end else begin
              // Low nibble is already registered on SIO_O, so rd_data_q is
              // free to take the next byte.
              cnt_d    = 2'd0;
              addr_d   = addr_inc;
              mem_re   = 1'b1;
              mem_addr = addr_inc;
            end
          end
        end
`ifdef QSPI_TGT_MODE_REG_EN
        ST_WRMR: begin
          if (rise_v) begin
            if (cnt_q == 2'd0) begin
              hi_d  = sio_s;
              cnt_d = 2'd1;
            end else begin
              mr_d    = {hi_q, sio_s};
              cnt_d   = 2'd0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_RDMR: begin
          if (rise_v) begin
            cnt_d = {1'b0, ~cnt_q[0]};
          end
        end
`endif
        ST_IGNORE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output next-state: pins only change on SCK falls.
  always_comb begin
    sio_o_d   = sio_o_q;
    sio_e_d   = sio_e_q;
    cmd_err_d = bad_cmd;
    if (cs_n_s) begin
      sio_o_d = 4'd0;
      sio_e_d = 4'd0;
    end else if (fall_v) begin
      if (state_q == ST_RDATA) begin
        sio_e_d = 4'hF;
        sio_o_d = cnt_q[0] ? rd_data_q[3:0] : rd_data_q[7:4];
      end
`ifdef QSPI_TGT_MODE_REG_EN
      else if (state_q == ST_RDMR) begin
        sio_e_d = 4'hF;
        sio_o_d = cnt_q[0] ? mr_q[3:0] : mr_q[7:4];
      end
`endif
    end
  end

  // Single-port array: one read or one write per CLK, never both.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end else if (mem_re) begin
      rd_data_q <= mem[mem_addr];
    end
  end

  assign bus.QSPI_SIO_O = sio_o_q;
  assign bus.QSPI_SIO_E = sio_e_q;
  assign bus.BUSY       = ~cs_n_s;
  assign bus.CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_qspi_sram_target.sv
// Testbench tb_qspi_sram_target
// Directed QSPI transactions against qspi_sram_target (ADDR_W=10, SYNC_N=2)
// with hand-computed expected data. Honours QSPI_TGT_MODE_REG_EN.
module tb_qspi_sram_target;

  localparam int H = 8;  // SCK half period in CLK cycles

  logic clk;
  logic res;
  int   compared;
  int   mismatched;
  int   err_cyc;   // running count of CLK cycles with CMD_ERR high
  int   oe_cyc;    // running count of CLK cycles with any SIO_E high

  qspi_sram_target_if bus ();

  qspi_sram_target #(.ADDR_W(10), .SYNC_N(2)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.CMD_ERR) err_cyc++;
    if (bus.QSPI_SIO_E != 4'd0) oe_cyc++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_lo();
    bus.QSPI_CS_N = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_hi();
    bus.QSPI_SCK  = 1'b0;
    bus.QSPI_CS_N = 1'b1;
    wait_clk(H);
  endtask

  // One SCK period: drive d while low, sample target outputs just before rise.
  task automatic nib(input logic [3:0] d, output logic [3:0] q, output logic [3:0] e);
    bus.QSPI_SIO_I = d;
    wait_clk(H);
    q = bus.QSPI_SIO_O;
    e = bus.QSPI_SIO_E;
    bus.QSPI_SCK = 1'b1;
    wait_clk(H);
    bus.QSPI_SCK = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] d);
    logic [3:0] q, e;
    nib(d, q, e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic [3:0] e);
    logic [3:0] h, l, e1, e2;
    nib(4'd0, h, e1);
    nib(4'd0, l, e2);
    b = {h, l};
    e = e1 & e2;
  endtask

  // Bytes are taken from d MSB first.
  task automatic do_write(input logic [15:0] a, input int n, input logic [31:0] d);
    cs_lo();
    send_byte(8'h02);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < n; i++) send_byte(d[31-8*i -: 8]);
    cs_hi();
    $display("tb: write @%h n=%0d data=%h", a, n, d);
  endtask

  // Result is right-aligned in d; e is the AND of SIO_E over all data nibbles.
  task automatic do_read(input logic [15:0] a, input int n, output logic [31:0] d, output logic [3:0] e);
    logic [7:0] b;
    logic [3:0] eb;
    cs_lo();
    send_byte(8'h03);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_nib(4'd0);
    send_nib(4'd0);
    d = 32'd0;
    e = 4'hF;
    for (int i = 0; i < n; i++) begin
      recv_byte(b, eb);
      d = {d[23:0], b};
      e = e & eb;
    end
    cs_hi();
    $display("tb: read  @%h n=%0d data=%h", a, n, d);
  endtask

  task automatic test_reset();
    res = 1'b1;
    bus.QSPI_CS_N  = 1'b1;
    bus.QSPI_SCK   = 1'b0;
    bus.QSPI_SIO_I = 4'd0;
    wait_clk(4);
    compared++;
    if (bus.QSPI_SIO_O !== 4'd0) begin mismatched++; $display("FAIL reset_sio_o: got %h required 0", bus.QSPI_SIO_O); end
    compared++;
    if (bus.QSPI_SIO_E !== 4'd0) begin mismatched++; $display("FAIL reset_sio_e: got %h required 0", bus.QSPI_SIO_E); end
    compared++;
    if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", bus.BUSY); end
    compared++;
    if (bus.CMD_ERR !== 1'b0) begin mismatched++; $display("FAIL reset_cmd_err: got %b required 0", bus.CMD_ERR); end
    res = 1'b0;
    wait_clk(4);
    // CS_N toggle with no SCK edges: BUSY follows, nothing else happens.
    cs_lo();
    compared++;
    if (bus.BUSY !== 1'b1) begin mismatched++; $display("FAIL busy_cs_low: got %b required 1", bus.BUSY); end
    cs_hi();
    compared++;
    if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL busy_cs_high: got %b required 0", bus.BUSY); end
    $display("tb: reset and empty chip-select done");
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [3:0]  e;
    int          err0;
    err0 = err_cyc;
    do_write(16'h0010, 2, 32'hA53C_0000);
    do_read(16'h0010, 2, d, e);
    compared++;
    if (d[15:0] !== 16'hA53C) begin mismatched++; $display("FAIL basic_read: got %h required a53c", d[15:0]); end
    compared++;
    if (e !== 4'hF) begin mismatched++; $display("FAIL basic_sio_e: got %h required f", e); end
    compared++;
    if (err_cyc - err0 !== 0) begin mismatched++; $display("FAIL basic_cmd_err: got %0d cycles required 0", err_cyc - err0); end
    // Bit 10 and above of the bus address are ignored.
    do_read(16'h0410, 1, d, e);
    compared++;
    if (d[7:0] !== 8'hA5) begin mismatched++; $display("FAIL alias_read: got %h required a5", d[7:0]); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [3:0]  e;
    do_write(16'h03FE, 4, 32'h1122_3344);
    do_read(16'h03FE, 4, d, e);
    compared++;
    if (d !== 32'h1122_3344) begin mismatched++; $display("FAIL wrap_read: got %h required 11223344", d); end
    do_read(16'h0000, 2, d, e);
    compared++;
    if (d[15:0] !== 16'h3344) begin mismatched++; $display("FAIL wrap_low_addr: got %h required 3344", d[15:0]); end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] d;
    logic [3:0]  e;
    int          err0, oe0;
    err0 = err_cyc;
    oe0  = oe_cyc;
    cs_lo();
    send_byte(8'h9F);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    cs_hi();
    $display("tb: command 9f");
    compared++;
    if (err_cyc - err0 !== 1) begin mismatched++; $display("FAIL badcmd_err_pulse: got %0d cycles required 1", err_cyc - err0); end
    compared++;
    if (oe_cyc - oe0 !== 0) begin mismatched++; $display("FAIL badcmd_sio_e: got %0d cycles required 0", oe_cyc - oe0); end
    do_read(16'h0010, 1, d, e);
    compared++;
    if (d[7:0] !== 8'hA5) begin mismatched++; $display("FAIL badcmd_next_read: got %h required a5", d[7:0]); end
  endtask

  task automatic test_partial_write();
    logic [31:0] d;
    logic [3:0]  e;
    do_write(16'h0020, 2, 32'h005A_0000);
    cs_lo();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h77);
    send_nib(4'h8);
    cs_hi();
    $display("tb: write @0020 77 + lone nibble 8");
    do_read(16'h0020, 2, d, e);
    compared++;
    if (d[15:0] !== 16'h775A) begin mismatched++; $display("FAIL partial_write: got %h required 775a", d[15:0]); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic [3:0]  e;
    logic [7:0]  b;
    logic [3:0]  q;
    do_write(16'h0100, 2, 32'hDEAD_0000);
    cs_lo();
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h00);
    send_nib(4'd0);
    send_nib(4'd0);
    recv_byte(b, e);
    compared++;
    if (b !== 8'hDE) begin mismatched++; $display("FAIL midread_first_byte: got %h required de", b); end
    nib(4'd0, q, e);
    wait_clk(H);
    compared++;
    if (bus.QSPI_SIO_E !== 4'hF) begin mismatched++; $display("FAIL midread_sio_e_active: got %h required f", bus.QSPI_SIO_E); end
    res = 1'b1;
    wait_clk(1);
    compared++;
    if (bus.QSPI_SIO_E !== 4'd0) begin mismatched++; $display("FAIL res_sio_e: got %h required 0", bus.QSPI_SIO_E); end
    compared++;
    if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL res_busy: got %b required 0", bus.BUSY); end
    res = 1'b0;
    cs_hi();
    $display("tb: reset during read data");
    do_read(16'h0100, 2, d, e);
    compared++;
    if (d[15:0] !== 16'hDEAD) begin mismatched++; $display("FAIL res_data_kept: got %h required dead", d[15:0]); end
  endtask

  task automatic test_mode_reg();
    int err0, oe0;
`ifdef QSPI_TGT_MODE_REG_EN
    logic [31:0] d;
    logic [3:0]  e;
    logic [7:0]  b;
    do_write(16'h0005, 2, 32'h6699_0000);
    cs_lo();
    send_byte(8'h01);
    send_byte(8'h00);
    cs_hi();
    $display("tb: WRMR 00");
    do_read(16'h0005, 3, d, e);
    compared++;
    if (d[23:0] !== 24'h666666) begin mismatched++; $display("FAIL byte_mode_read: got %h required 666666", d[23:0]); end
    err0 = err_cyc;
    oe0  = oe_cyc;
    cs_lo();
    send_byte(8'h05);
    recv_byte(b, e);
    compared++;
    if (b !== 8'h00) begin mismatched++; $display("FAIL rdmr_first: got %h required 00", b); end
    recv_byte(b, e);
    compared++;
    if (b !== 8'h00 || e !== 4'hF) begin mismatched++; $display("FAIL rdmr_repeat: got %h/%h required 00/f", b, e); end
    cs_hi();
    $display("tb: RDMR");
    compared++;
    if (err_cyc - err0 !== 0) begin mismatched++; $display("FAIL rdmr_cmd_err: got %0d cycles required 0", err_cyc - err0); end
    if (oe_cyc == oe0) $display("tb: note rdmr drove no output");
    cs_lo();
    send_byte(8'h01);
    send_byte(8'h40);
    cs_hi();
    $display("tb: WRMR 40");
`else
    err0 = err_cyc;
    oe0  = oe_cyc;
    cs_lo();
    send_byte(8'h01);
    send_byte(8'h00);
    cs_hi();
    $display("tb: command 01 without mode register");
    compared++;
    if (err_cyc - err0 !== 1) begin mismatched++; $display("FAIL wrmr_unsupported: got %0d cycles required 1", err_cyc - err0); end
    err0 = err_cyc;
    cs_lo();
    send_byte(8'h05);
    send_byte(8'h00);
    cs_hi();
    $display("tb: command 05 without mode register");
    compared++;
    if (err_cyc - err0 !== 1) begin mismatched++; $display("FAIL rdmr_unsupported: got %0d cycles required 1", err_cyc - err0); end
    compared++;
    if (oe_cyc - oe0 !== 0) begin mismatched++; $display("FAIL rdmr_unsupported_sio_e: got %0d cycles required 0", oe_cyc - oe0); end
`endif
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    err_cyc    = 0;
    oe_cyc     = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_bad_cmd();
    test_partial_write();
    test_reset_mid_read();
    test_mode_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
